// File: rtl/pipe_pkg.sv
// Shared types and widths for the elastic pipeline stage.
package pipe_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned IFID_W  = PC_W + INSTR_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } stage_state_t;

  // Default IF/ID payload: PC in the upper half, instruction in the lower half.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ifid_payload_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter; sticks at all-ones.
module pipe_sat_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         start_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer, flush and hold.
// Optional stall/flush counters under PIPE_SKID_STAGE_PERF_EN.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = IFID_W,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
`ifdef PIPE_SKID_STAGE_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
`endif
  output logic [DATA_W-1:0] data_o
);

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("pipe_skid_stage: CNT_W must be at least 1");
  end

  stage_state_t      state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              accept;
  logic              emit;

  assign accept = valid_i & ready_q & ~hold_i & ~flush_i;
  assign emit   = valid_q & ready_i & ~hold_i;

  // Next state; hold needs no branch since accept/emit are already gated by it.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      data_d  = FLUSH_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            data_d  = data_i;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            data_d = data_i;
          end else if (accept) begin
            state_d = ST_TWO;
            skid_d  = data_i;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (emit) begin
            state_d = ST_ONE;
            data_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q <= ST_EMPTY;
      data_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign valid_o = valid_q;
  assign ready_o = ready_q;
  assign data_o  = data_q;

`ifdef PIPE_SKID_STAGE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = valid_q & ~ready_i & ~hold_i;
  assign flush_inc = flush_i & valid_q;

  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .start_i (start_i),
    .inc_i   (stall_inc),
    .cnt_o   (stall_cnt_o)
  );

  pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .start_i (start_i),
    .inc_i   (flush_inc),
    .cnt_o   (flush_cnt_o)
  );
`endif

endmodule
